// File: rtl/md5_sched_pkg.sv
// md5_sched_pkg: shared state encoding, padding byte and block index
// constants for the MD5 padding scheduler, plus the last-word formatter.
package md5_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_PAD,
        S_LENLO,
        S_LENHI,
        S_WAIT
    } state_t;

    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam logic [3:0] IDX_LENLO   = 4'd14;
    localparam logic [3:0] IDX_LENHI   = 4'd15;
    // Last index that can still be followed directly by the length words.
    localparam logic [3:0] IDX_PRE_LEN = IDX_LENLO - 4'd1;

    // Keep nb valid bytes (0 means 4), append the pad byte, zero the rest.
    function automatic logic [31:0] last_word(input logic [31:0] d,
                                              input logic [1:0]  nb);
        logic [31:0] r;
        unique case (nb)
            2'd1:    r = {16'h0, PAD_BYTE, d[7:0]};
            2'd2:    r = {8'h0, PAD_BYTE, d[15:0]};
            2'd3:    r = {PAD_BYTE, d[23:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md5_tmo_cnt.sv
// md5_tmo_cnt: counts cycles while en is high; expired is high in the
// cycle that is number DONE_TMO+1 of a continuous en run.
// Ports: clk, rst (sync, active-high), en (count enable, clears when low),
//        expired (timeout reached).
module md5_tmo_cnt #(
    parameter int unsigned DONE_TMO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(DONE_TMO + 2);
    localparam logic [W-1:0] LIM = W'(DONE_TMO);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == LIM);

    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = expired ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/md5_pad_sched.sv
// md5_pad_sched: accepts little-endian message words, appends MD5 padding
// and the 64-bit bit length, and streams 16-word blocks to the MD5 core.
// Ports: clk, rst (sync, active-high); msgVld/msgRdy/msgData/msgLast/
//        msgBytes message input; coreVld/coreData/coreFirst word output;
//        coreBlkDone block-complete pulse; schedBusy; tmoErr (sticky).
// Option: define MD5_SCHED_BLKCNT_EN to add the blkCnt block counter.
module md5_pad_sched
    import md5_sched_pkg::*;
#(
    parameter int unsigned DONE_TMO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msgVld,
    output logic        msgRdy,
    input  logic [31:0] msgData,
    input  logic        msgLast,
    input  logic [1:0]  msgBytes,
    output logic        coreVld,
    output logic [31:0] coreData,
    output logic        coreFirst,
    input  logic        coreBlkDone,
    output logic        schedBusy,
`ifdef MD5_SCHED_BLKCNT_EN
    output logic [15:0] blkCnt,
`endif
    output logic        tmoErr
);

    state_t       state_q, state_d;
    logic         run_q;
    logic [3:0]   idx_q, idx_d;
    logic [60:0]  bcnt_q, bcnt_d;
    logic         vld_q, vld_d;
    logic [31:0]  data_q, data_d;
    logic         first_q, first_d;
    logic         tmo_q, tmo_d;
    logic         last_seen_q, last_seen_d;
    logic         pad_done_q, pad_done_d;
    logic         len_done_q, len_done_d;
`ifdef MD5_SCHED_BLKCNT_EN
    logic [15:0]  blk_q, blk_d;
`endif

    logic         accept;
    logic         expired;
    logic         part_last;
    logic [60:0]  add;
    logic [63:0]  bitlen;

    // run_q holds msgRdy low until the first cycle after reset releases.
    assign msgRdy    = run_q && (state_q == S_IDLE || state_q == S_MSG);
    assign accept    = msgVld && msgRdy;
    assign part_last = msgLast && (msgBytes != 2'd0);
    assign add       = part_last ? {59'd0, msgBytes} : 61'd4;
    assign bitlen    = {bcnt_q, 3'b000};

    assign coreVld   = vld_q;
    assign coreData  = data_q;
    assign coreFirst = first_q;
    assign schedBusy = (state_q != S_IDLE);
    assign tmoErr    = tmo_q;
`ifdef MD5_SCHED_BLKCNT_EN
    assign blkCnt    = blk_q;
`endif

    md5_tmo_cnt #(
        .DONE_TMO(DONE_TMO)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == S_WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            first_q     <= 1'b0;
            tmo_q       <= 1'b0;
            last_seen_q <= 1'b0;
            pad_done_q  <= 1'b0;
            len_done_q  <= 1'b0;
`ifdef MD5_SCHED_BLKCNT_EN
            blk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            first_q     <= first_d;
            tmo_q       <= tmo_d;
            last_seen_q <= last_seen_d;
            pad_done_q  <= pad_done_d;
            len_done_q  <= len_done_d;
`ifdef MD5_SCHED_BLKCNT_EN
            blk_q       <= blk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_MSG: begin
                if (accept) begin
                    if (idx_q == IDX_LENHI) begin
                        state_d = S_WAIT;
                    end else if (!msgLast) begin
                        state_d = S_MSG;
                    end else if (part_last && idx_q == IDX_PRE_LEN) begin
                        state_d = S_LENLO;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            // Every PAD emission leaves the pad byte placed.
            S_PAD: begin
                if (idx_q == IDX_LENHI) begin
                    state_d = S_WAIT;
                end else if (idx_q == IDX_PRE_LEN) begin
                    state_d = S_LENLO;
                end
            end
            S_LENLO: state_d = S_LENHI;
            S_LENHI: state_d = S_WAIT;
            S_WAIT: begin
                if (coreBlkDone) begin
                    if (len_done_q) begin
                        state_d = S_IDLE;
                    end else if (last_seen_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_MSG;
                    end
                end else if (expired) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        vld_d       = 1'b0;
        data_d      = data_q;
        first_d     = 1'b0;
        tmo_d       = tmo_q;
        last_seen_d = last_seen_q;
        pad_done_d  = pad_done_q;
        len_done_d  = len_done_q;
`ifdef MD5_SCHED_BLKCNT_EN
        blk_d       = blk_q;
`endif
        unique case (state_q)
            S_IDLE, S_MSG: begin
                if (accept) begin
                    vld_d       = 1'b1;
                    idx_d       = idx_q + 4'd1;
                    data_d      = msgLast ? last_word(msgData, msgBytes)
                                          : msgData;
                    last_seen_d = msgLast;
                    pad_done_d  = part_last;
                    if (state_q == S_IDLE) begin
                        first_d    = 1'b1;
                        tmo_d      = 1'b0;
                        bcnt_d     = add;
                        len_done_d = 1'b0;
`ifdef MD5_SCHED_BLKCNT_EN
                        blk_d      = '0;
`endif
                    end else begin
                        bcnt_d = bcnt_q + add;
                    end
                end
            end
            S_PAD: begin
                vld_d      = 1'b1;
                idx_d      = idx_q + 4'd1;
                data_d     = pad_done_q ? 32'h0 : {24'h0, PAD_BYTE};
                pad_done_d = 1'b1;
            end
            S_LENLO: begin
                vld_d  = 1'b1;
                idx_d  = idx_q + 4'd1;
                data_d = bitlen[31:0];
            end
            S_LENHI: begin
                vld_d      = 1'b1;
                idx_d      = idx_q + 4'd1;
                data_d     = bitlen[63:32];
                len_done_d = 1'b1;
            end
            S_WAIT: begin
                if (coreBlkDone) begin
`ifdef MD5_SCHED_BLKCNT_EN
                    if (blk_q != 16'hFFFF) begin
                        blk_d = blk_q + 16'd1;
                    end
`endif
                    if (len_done_q) begin
                        bcnt_d      = '0;
                        last_seen_d = 1'b0;
                        pad_done_d  = 1'b0;
                        len_done_d  = 1'b0;
                    end
                end else if (expired) begin
                    tmo_d       = 1'b1;
                    idx_d       = '0;
                    bcnt_d      = '0;
                    last_seen_d = 1'b0;
                    pad_done_d  = 1'b0;
                    len_done_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/md5_pad_sched.md
MD5_PAD_SCHED -- requirements
Module: md5_pad_sched

Interface
REQ-001 SHALL have parameter DONE_TMO, default 255, meaning the maximum number of cycles to wait for coreBlkDone after the 16th word of a block.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port msgVld, input, 1, message word valid.
REQ-005 SHALL have port msgRdy, output, 1, message word accepted when msgVld&msgRdy.
REQ-006 SHALL have port msgData, input, 32, message word, byte 0 in bits [7:0] (little-endian).
REQ-007 SHALL have port msgLast, input, 1, final word of the message.
REQ-008 SHALL have port msgBytes, input, 2, valid bytes in the last word; 0 means 4.
REQ-009 SHALL have port coreVld, output, 1, word presented to the MD5 core this cycle.
REQ-010 SHALL have port coreData, output, 32, padded block word to the core.
REQ-011 SHALL have port coreFirst, output, 1, qualifies the first word of a message so the core reloads its IV.
REQ-012 SHALL have port coreBlkDone, input, 1, one-cycle pulse when the core finishes a block.
REQ-013 SHALL have port schedBusy, output, 1, high from the first accepted word until the final block completes.
REQ-014 SHALL have port tmoErr, output, 1, sticky timeout flag.

Function
REQ-015 SHALL use states IDLE, MSG, PAD, LENLO, LENHI, WAIT.
REQ-016 SHALL hold msgRdy high only in IDLE, and in MSG while the word index is below 16.
REQ-017 SHALL register each accepted word onto coreData with coreVld high exactly one cycle after acceptance.
REQ-018 SHALL keep a 4-bit word index, incremented on every coreVld.
REQ-019 SHALL enter WAIT after index 15 and resume at index 0 only on coreBlkDone.
REQ-020 SHALL count message bytes in a 61-bit counter, adding 4 per word, or msgBytes (0 meaning 4) on the last word.
REQ-021 SHALL form the last word with k=1..3 valid bytes as: data bytes, then 0x80 at byte k, then zero bytes.
REQ-022 SHALL emit the next word as 0x00000080 when the last word holds 4 valid bytes.
REQ-023 SHALL fill PAD with zero words until index 14.
REQ-024 SHALL place the 0x80 byte at index 14 or 15 when the message requires it, and SHALL then zero-fill to 15, wait for coreBlkDone, and pad a further block.
REQ-025 SHALL emit LENLO at index 14 as bit-length[31:0] and LENHI at index 15 as bit-length[63:32], where bit-length = byte count << 3.
REQ-026 SHALL, after coreBlkDone on the length block, return to IDLE, drop schedBusy and clear the byte counter.
REQ-027 SHALL assert coreFirst with coreVld only for word 0 of block 0 of a message.
REQ-028 SHALL not support zero-length messages; every message carries at least one word.
REQ-029 SHALL ignore coreBlkDone outside WAIT.
REQ-030 SHALL, when WAIT exceeds DONE_TMO cycles, set tmoErr and return to IDLE, discarding the message.
REQ-031 SHALL clear tmoErr on the next accepted first word.

Reset
REQ-032 SHALL, on rst, drive state to IDLE and force msgRdy, coreVld, coreData, coreFirst, schedBusy, tmoErr, counters and word index to 0, with msgRdy rising the cycle after rst deasserts.
REQ-033 SHALL, on rst asserted mid-message, abandon the message with no further coreVld.

Configuration
REQ-034 SHALL, with MD5_SCHED_BLKCNT_EN defined, add output blkCnt (16 bits) counting blocks completed in the current message, cleared at message start and saturating at 0xFFFF.
REQ-035 SHALL, without MD5_SCHED_BLKCNT_EN, omit blkCnt and its counter.

Structure
REQ-036 SHALL take state encodings, the padding byte 0x80 and index constants 14/15 from a shared package md5_sched_pkg.
REQ-037 SHALL implement the optional timeout counter as sub-module md5_tmo_cnt.

Verification
REQ-038 SHALL test "abc": msgData 0x00636261, msgLast=1, msgBytes=3 -> coreData 0x80636261, 13 zero words, 0x00000018, 0x00000000; coreFirst on word 0 only; one block.
REQ-039 SHALL test 14 full words (56 bytes): 0x00000080 at index 14, zero at 15, WAIT, then a second block of 14 zeros, 0x000001C0, 0x00000000.
REQ-040 SHALL test 55 bytes (last word msgBytes=3 at index 13): 0x80 at byte 3 of index 13, length 0x000001B8 at 14; one block.
REQ-041 SHALL test withholding coreBlkDone for DONE_TMO+1 cycles: tmoErr=1, state IDLE, msgRdy=1.
REQ-042 SHALL test rst asserted at index 7: next cycle coreVld=0, schedBusy=0; a following "abc" message reproduces REQ-038 exactly.
REQ-043 SHALL test a coreBlkDone pulse in IDLE: no state change.
